// File: rtl/dt_backward_scanner.sv
// dt_backward_scanner
// Backward-raster pass of the distance transform. The pass walks the image
// interior from the bottom-right pixel (IMG_W-2, IMG_H-2) to the top-left
// pixel (1, 1). For every non-zero centre it reads the four neighbours that
// come later in raster order: right, bottom-left, bottom and bottom-right.
// It then writes back min(centre, min(neighbours) + 1), with the +1
// saturating at the all-ones value.
//
// Ports
//   clk       rising-edge clock
//   reset     asynchronous, active-high reset
//   start     one-cycle pulse; starts a pass when idle, ignored otherwise
//   busy      high from the cycle after an accepted start through the done
//             cycle
//   done      one-cycle pulse at the end of a pass
//   res_addr  result RAM address (y*IMG_W + x)
//   res_rd    RAM read strobe; data comes back on res_do in the next cycle
//   res_do    RAM read data
//   res_wr    RAM write strobe
//   res_di    RAM write data
module dt_backward_scanner #(
  parameter int DATA_WIDTH = 8,
  parameter int IMG_W      = 128,
  parameter int IMG_H      = 128,
  parameter int ADDR_WIDTH = 14
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] res_addr,
  output logic                  res_rd,
  input  logic [DATA_WIDTH-1:0] res_do,
  output logic                  res_wr,
  output logic [DATA_WIDTH-1:0] res_di
);

  typedef enum logic [3:0] {
    S_IDLE  = 4'd0,
    S_RD_C  = 4'd1,
    S_CHK   = 4'd2,
    S_RD_N0 = 4'd3,
    S_RD_N1 = 4'd4,
    S_RD_N2 = 4'd5,
    S_RD_N3 = 4'd6,
    S_CAP   = 4'd7,
    S_WR    = 4'd8,
    S_NEXT  = 4'd9,
    S_DONE  = 4'd10
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] X_START = ADDR_WIDTH'(IMG_W - 2);
  localparam logic [ADDR_WIDTH-1:0] Y_START = ADDR_WIDTH'(IMG_H - 2);
  localparam logic [ADDR_WIDTH-1:0] ROW_LEN = ADDR_WIDTH'(IMG_W);
  localparam logic [ADDR_WIDTH-1:0] ONE_A   = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0] ZERO_A  = {ADDR_WIDTH{1'b0}};
  localparam logic [DATA_WIDTH-1:0] ZERO_D  = {DATA_WIDTH{1'b0}};
  localparam logic [DATA_WIDTH-1:0] ONE_D   = DATA_WIDTH'(1);
  localparam logic [DATA_WIDTH-1:0] MAX_D   = {DATA_WIDTH{1'b1}};

  function automatic logic [ADDR_WIDTH-1:0] pix_addr(input logic [ADDR_WIDTH-1:0] px,
                                                     input logic [ADDR_WIDTH-1:0] py);
    return py * ROW_LEN + px;
  endfunction

  function automatic logic [DATA_WIDTH-1:0] umin(input logic [DATA_WIDTH-1:0] a,
                                                 input logic [DATA_WIDTH-1:0] b);
    return (a < b) ? a : b;
  endfunction

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   x_q, x_d, y_q, y_d;
  logic [DATA_WIDTH-1:0]   center_q, center_d;
  logic [DATA_WIDTH-1:0]   n0_q, n0_d, n1_q, n1_d, n2_q, n2_d;
  logic                    busy_q, busy_d, done_q, done_d;
  logic                    res_rd_q, res_rd_d, res_wr_q, res_wr_d;
  logic [ADDR_WIDTH-1:0]   res_addr_q, res_addr_d;
  logic [DATA_WIDTH-1:0]   res_di_q, res_di_d;
  logic [DATA_WIDTH-1:0]   m_s, m1_s, result_s;

  assign busy     = busy_q;
  assign done     = done_q;
  assign res_rd   = res_rd_q;
  assign res_wr   = res_wr_q;
  assign res_addr = res_addr_q;
  assign res_di   = res_di_q;

  // State, scan position, captured pixels and registered RAM-side outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      x_q        <= X_START;
      y_q        <= Y_START;
      center_q   <= ZERO_D;
      n0_q       <= ZERO_D;
      n1_q       <= ZERO_D;
      n2_q       <= ZERO_D;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      res_rd_q   <= 1'b0;
      res_wr_q   <= 1'b0;
      res_addr_q <= ZERO_A;
      res_di_q   <= ZERO_D;
    end else begin
      state_q    <= state_d;
      x_q        <= x_d;
      y_q        <= y_d;
      center_q   <= center_d;
      n0_q       <= n0_d;
      n1_q       <= n1_d;
      n2_q       <= n2_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      res_rd_q   <= res_rd_d;
      res_wr_q   <= res_wr_d;
      res_addr_q <= res_addr_d;
      res_di_q   <= res_di_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_RD_C;
        else       state_d = S_IDLE;
      end
      S_RD_C:  state_d = S_CHK;
      S_CHK: begin
        // Background pixels skip the neighbour reads and the write.
        if (res_do == ZERO_D) state_d = S_NEXT;
        else                  state_d = S_RD_N0;
      end
      S_RD_N0: state_d = S_RD_N1;
      S_RD_N1: state_d = S_RD_N2;
      S_RD_N2: state_d = S_RD_N3;
      S_RD_N3: state_d = S_CAP;
      S_CAP:   state_d = S_WR;
      S_WR:    state_d = S_NEXT;
      S_NEXT: begin
        if (x_q == ONE_A && y_q == ONE_A) state_d = S_DONE;
        else                              state_d = S_RD_C;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Scan position and captured read data. Each read returns one cycle after
  // its strobe, so each value is taken in the state that follows its read.
  always_comb begin
    x_d      = x_q;
    y_d      = y_q;
    center_d = center_q;
    n0_d     = n0_q;
    n1_d     = n1_q;
    n2_d     = n2_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          x_d = X_START;
          y_d = Y_START;
        end else begin
          x_d = x_q;
        end
      end
      S_CHK:   center_d = res_do;
      S_RD_N1: n0_d = res_do;
      S_RD_N2: n1_d = res_do;
      S_RD_N3: n2_d = res_do;
      S_NEXT: begin
        if (x_q == ONE_A) begin
          if (y_q != ONE_A) begin
            x_d = X_START;
            y_d = y_q - ONE_A;
          end else begin
            y_d = y_q;
          end
        end else begin
          x_d = x_q - ONE_A;
        end
      end
      default: x_d = x_q;
    endcase
  end

  // Candidate value. In CAP the fourth neighbour is still on res_do. That is
  // the only state where result_s is used.
  always_comb begin
    m_s = umin(umin(n0_q, n1_q), umin(n2_q, res_do));
    if (m_s == MAX_D) m1_s = MAX_D;
    else              m1_s = m_s + ONE_D;
    result_s = umin(center_q, m1_s);
  end

  // Registered outputs are computed from the state being entered, so each
  // access strobe lines up with its own state.
  always_comb begin
    busy_d     = (state_d != S_IDLE);
    done_d     = (state_d == S_DONE);
    res_rd_d   = 1'b0;
    res_wr_d   = 1'b0;
    res_addr_d = ZERO_A;
    res_di_d   = ZERO_D;
    case (state_d)
      S_RD_C: begin
        res_rd_d   = 1'b1;
        res_addr_d = pix_addr(x_d, y_d);
      end
      S_RD_N0: begin
        res_rd_d   = 1'b1;
        res_addr_d = pix_addr(x_d + ONE_A, y_d);
      end
      S_RD_N1: begin
        res_rd_d   = 1'b1;
        res_addr_d = pix_addr(x_d - ONE_A, y_d + ONE_A);
      end
      S_RD_N2: begin
        res_rd_d   = 1'b1;
        res_addr_d = pix_addr(x_d, y_d + ONE_A);
      end
      S_RD_N3: begin
        res_rd_d   = 1'b1;
        res_addr_d = pix_addr(x_d + ONE_A, y_d + ONE_A);
      end
      S_WR: begin
        res_wr_d   = 1'b1;
        res_addr_d = pix_addr(x_d, y_d);
        res_di_d   = result_s;
      end
      default: res_rd_d = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_dt_backward_scanner.sv
// Bench for dt_backward_scanner on an 8x8 image. A RAM model answers the
// DUT's accesses. A reference model computes the backward pass directly on an
// array and queues the expected writes. A monitor compares every write
// against that queue.
module tb_dt_backward_scanner;
  localparam int DW = 8;
  localparam int W  = 8;
  localparam int H  = 8;
  localparam int AW = 6;
  localparam int N  = W * H;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic          busy, done, res_rd, res_wr;
  logic [AW-1:0] res_addr;
  logic [DW-1:0] res_do, res_di;

  logic [DW-1:0] mem [N];
  int            ref_img [N];

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;
  wr_t exp_q[$];

  int errors = 0;
  int checks = 0;
  int busy_cnt = 0;
  int done_cnt = 0;
  int first_rd = -1;
  bit got_rd = 1'b0;

  always #5 clk = ~clk;

  dt_backward_scanner #(
    .DATA_WIDTH(DW), .IMG_W(W), .IMG_H(H), .ADDR_WIDTH(AW)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
    .res_addr(res_addr), .res_rd(res_rd), .res_do(res_do),
    .res_wr(res_wr), .res_di(res_di)
  );

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic set_all(input int v);
    for (int i = 0; i < N; i++) mem[i] = DW'(v);
  endtask

  function automatic int min2(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  // Backward pass worked out on ref_img, in place, in reverse raster order.
  // Returns the expected number of busy cycles: 3 per background pixel,
  // 9 per object pixel, plus 1 for the done cycle.
  function automatic int model_pass();
    int cyc;
    int a, c, m, m1, r;
    wr_t e;
    cyc = 0;
    for (int y = H - 2; y >= 1; y--) begin
      for (int x = W - 2; x >= 1; x--) begin
        a = y * W + x;
        c = ref_img[a];
        if (c == 0) begin
          cyc += 3;
        end else begin
          m  = min2(min2(ref_img[a + 1], ref_img[a + W - 1]),
                    min2(ref_img[a + W], ref_img[a + W + 1]));
          m1 = min2(m + 1, (1 << DW) - 1);
          r  = min2(c, m1);
          ref_img[a] = r;
          e.addr = a[AW-1:0];
          e.data = r[DW-1:0];
          exp_q.push_back(e);
          cyc += 9;
        end
      end
    end
    return cyc + 1;
  endfunction

  task automatic do_pass(input bit extra_starts, input bit start_in_done);
    int exp_busy;
    bit seen;
    for (int i = 0; i < N; i++) ref_img[i] = int'(mem[i]);
    exp_q.delete();
    exp_busy = model_pass();
    busy_cnt = 0;
    done_cnt = 0;
    got_rd   = 1'b0;
    first_rd = -1;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 3000 && !seen; c++) begin
      if (done) begin
        seen = 1'b1;
      end else begin
        if (extra_starts && $urandom_range(0, 7) == 0) start = 1'b1;
        @(negedge clk);
        start = 1'b0;
      end
    end
    check("done_within_budget", int'(seen), 1);
    if (start_in_done) begin
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("start_in_done_ignored", int'(busy), 0);
    end else begin
      @(negedge clk);
    end
    @(negedge clk);
    check("done_pulses", done_cnt, 1);
    check("busy_cycles", busy_cnt, exp_busy);
    check("busy_after_done", int'(busy), 0);
    check("first_read_addr", first_rd, (H - 2) * W + (W - 2));
    check("writes_outstanding", exp_q.size(), 0);
    for (int i = 0; i < N; i++) check("ram_final", int'(mem[i]), ref_img[i]);
  endtask

  initial begin
    wr_t e;
    bit seen;
    reset = 1'b1;
    start = 1'b0;
    res_do = '0;
    set_all(0);
    fork
      // RAM model: synchronous read, data valid the cycle after res_rd.
      forever begin
        @(posedge clk);
        if (res_wr) mem[res_addr] <= res_di;
        if (res_rd) res_do <= mem[res_addr];
      end
      // Monitor: counts busy and done cycles, and checks each write against
      // the scoreboard.
      forever begin
        @(negedge clk);
        if (busy) busy_cnt++;
        if (done) done_cnt++;
        if (res_rd && !got_rd) begin
          got_rd   = 1'b1;
          first_rd = int'(res_addr);
        end
        if (res_rd || res_wr) check("rd_wr_exclusive", int'(res_rd & res_wr), 0);
        if (res_wr) begin
          check("write_expected", int'(exp_q.size() > 0), 1);
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("write_addr", int'(res_addr), int'(e.addr));
            check("write_data", int'(res_di), int'(e.data));
          end
        end
      end
    join_none

    repeat (3) @(negedge clk);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_res_rd", int'(res_rd), 0);
    check("rst_res_wr", int'(res_wr), 0);
    check("rst_res_addr", int'(res_addr), 0);
    check("rst_res_di", int'(res_di), 0);
    reset = 1'b0;

    // All-zero image; start in the DONE cycle must be ignored.
    set_all(0);
    do_pass(1'b0, 1'b1);
    check("zero_img_busy", busy_cnt, 36 * 3 + 1);

    // Single object pixel at (3,3).
    set_all(0);
    mem[27] = 8'd5;
    do_pass(1'b0, 1'b0);
    check("single_pixel_value", int'(mem[27]), 1);

    // 3x3 block with forward-pass values.
    set_all(0);
    for (int y = 2; y <= 4; y++)
      for (int x = 2; x <= 4; x++) mem[y * W + x] = 8'd1;
    mem[27] = 8'd2;
    mem[35] = 8'd2;
    do_pass(1'b0, 1'b0);
    check("block_center", int'(mem[27]), 2);
    check("block_lower_mid", int'(mem[35]), 1);

    // Saturation: everything at full scale must stay at full scale.
    set_all(255);
    do_pass(1'b0, 1'b0);
    check("saturate_center", int'(mem[36]), 255);

    // Reset while in RD_N2 of the first object pixel (6,6).
    set_all(0);
    mem[54] = 8'd7;
    exp_q.delete();
    done_cnt = 0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 60 && !seen; c++) begin
      if (res_rd && int'(res_addr) == 62) seen = 1'b1;
      else @(negedge clk);
    end
    check("reached_rd_n2", int'(seen), 1);
    #2 reset = 1'b1;
    #1;
    check("midrst_res_rd", int'(res_rd), 0);
    check("midrst_res_wr", int'(res_wr), 0);
    check("midrst_busy", int'(busy), 0);
    check("midrst_addr", int'(res_addr), 0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    check("midrst_no_done", done_cnt, 0);
    check("midrst_ram_kept", int'(mem[54]), 7);
    do_pass(1'b0, 1'b0);

    // Random images, with stray start pulses during the pass.
    for (int t = 0; t < 4; t++) begin
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(0, 1) == 0) mem[i] = 8'd0;
        else if ($urandom_range(0, 9) == 0) mem[i] = 8'd255;
        else mem[i] = DW'($urandom_range(1, 20));
      end
      do_pass(1'b1, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
